// File: rtl/same_domain_reg_pipe_pkg.sv
// ---------------------------------------------------------------------------
// same_domain_reg_pipe_pkg
//
// Purpose:
//   Shared definitions for the same-clock-domain elastic register pipeline:
//   default geometry, the occupancy-width helper, the stage record type and
//   the occupancy update event encoding.
//
// Contents:
//   DEFAULT_WIDTH / DEFAULT_CHANNELS / DEFAULT_DEPTH  default geometry
//   occ_w(depth)                                      occupancy counter width
//   stage_rec_t                                       {valid, data} record
//   occ_event_t                                       push/pop event code
// ---------------------------------------------------------------------------
package same_domain_reg_pipe_pkg;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_CHANNELS = 1;
    localparam int DEFAULT_DEPTH    = 2;

    // Width needed to count 0..depth. A zero depth is rejected at
    // elaboration by the top level; returning 1 here keeps the port
    // declaration legal long enough for that message to be reported.
    function automatic int occ_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // One pipeline slot at the default geometry.
    typedef struct packed {
        logic                                       valid;
        logic [DEFAULT_CHANNELS*DEFAULT_WIDTH-1:0] data;
    } stage_rec_t;

    // Encoding is {push, pop} so the event can be formed by a direct cast.
    typedef enum logic [1:0] {
        OCC_HOLD = 2'b00,
        OCC_DEC  = 2'b01,
        OCC_INC  = 2'b10,
        OCC_SWAP = 2'b11
    } occ_event_t;

endpackage

// File: rtl/same_domain_reg_pipe_stage.sv
// ---------------------------------------------------------------------------
// same_domain_reg_pipe_stage
//
// Purpose:
//   One elastic slot of the pipeline: a valid bit plus a data register.
//   The slot can take a new beat whenever it is empty or its current beat
//   is leaving this cycle.
//
// Configuration macro:
//   SAME_DOMAIN_REG_PIPE_RESET_DATA_EN  when defined the data register is
//                                       reset to RST_DATA; otherwise only
//                                       the valid bit is reset.
//
// Ports:
//   clk          in   clock, rising edge
//   async_rst_n  in   asynchronous active-low reset
//   flush        in   synchronous clear of the valid bit
//   up_valid     in   beat offered by the previous slot (or the input)
//   up_data      in   data of that beat
//   down_ready   in   next slot (or the output) can take this slot's beat
//   ready        out  this slot can take a beat this cycle
//   valid        out  this slot holds a beat
//   data         out  this slot's data
// ---------------------------------------------------------------------------
module same_domain_reg_pipe_stage
    import same_domain_reg_pipe_pkg::*;
#(
    parameter int               BUS_W    = DEFAULT_CHANNELS * DEFAULT_WIDTH,
    parameter logic [BUS_W-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             async_rst_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [BUS_W-1:0] up_data,
    input  logic             down_ready,
    output logic             ready,
    output logic             valid,
    output logic [BUS_W-1:0] data
);

    // Combinational ready lets a full chain still advance one beat per cycle
    // when the head is being drained.
    assign ready = !valid || down_ready;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (ready) begin
            valid <= up_valid;
        end
    end

    // Data only moves with a real beat, so an emptied slot keeps showing the
    // last beat it held and a stalled slot never changes.
`ifdef SAME_DOMAIN_REG_PIPE_RESET_DATA_EN
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            data <= RST_DATA;
        end else if (ready && up_valid) begin
            data <= up_data;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (ready && up_valid) begin
            data <= up_data;
        end
    end

    logic unused_rst_data;
    assign unused_rst_data = ^RST_DATA;
`endif

endmodule

// File: rtl/same_domain_reg_pipe.sv
// ---------------------------------------------------------------------------
// same_domain_reg_pipe
//
// Purpose:
//   DEPTH-stage elastic register pipeline with a valid/ready handshake,
//   carrying CHANNELS lanes of WIDTH bits. Everything lives in one clock
//   domain, so no synchronisers are present. Full throughput: one beat per
//   cycle once filled; latency DEPTH-1 cycles after acceptance when not
//   stalled.
//
// Configuration macro:
//   SAME_DOMAIN_REG_PIPE_RESET_DATA_EN  when defined every stage's data
//                                       register resets to {CHANNELS{RST_VAL}};
//                                       otherwise data registers have no reset.
//
// Ports:
//   clk          in   1                 clock, rising edge
//   async_rst_n  in   1                 asynchronous active-low reset
//   flush        in   1                 synchronous drop of all held beats
//   in_valid     in   1                 upstream beat valid
//   in_ready     out  1                 pipe accepts a beat this cycle
//   in_data      in   CHANNELS*WIDTH    lane n at [n*WIDTH +: WIDTH]
//   out_valid    out  1                 head beat valid
//   out_ready    in   1                 downstream accepts head beat
//   out_data     out  CHANNELS*WIDTH    head beat data
//   occupancy    out  occ_w(DEPTH)      number of held beats, 0..DEPTH
// ---------------------------------------------------------------------------
module same_domain_reg_pipe
    import same_domain_reg_pipe_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter int               CHANNELS = DEFAULT_CHANNELS,
    parameter int               DEPTH    = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         async_rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*WIDTH-1:0]    out_data,
    output logic [occ_w(DEPTH)-1:0]      occupancy
);

    localparam int BUS_W = CHANNELS * WIDTH;
    localparam int OCC_W = occ_w(DEPTH);
    localparam logic [BUS_W-1:0] BUS_RST = {CHANNELS{RST_VAL}};

    if (DEPTH < 1) begin : g_depth_check
        $error("same_domain_reg_pipe: DEPTH must be at least 1");
    end

    // Index 0 is the pipe input, index i+1 is the output of stage i, so the
    // head stage drives index DEPTH.
    logic [DEPTH:0] chain_valid;
    logic [BUS_W-1:0] chain_data [DEPTH+1];
    logic [DEPTH:0] chain_ready;

    logic push;
    logic pop;
    occ_event_t occ_event;

    // A flush cycle refuses new beats so the clear cannot race an accept.
    assign in_ready = chain_ready[0] && !flush;

    assign chain_valid[0] = in_valid && in_ready;
    assign chain_data[0]  = in_data;
    assign chain_ready[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        same_domain_reg_pipe_stage #(
            .BUS_W    (BUS_W),
            .RST_DATA (BUS_RST)
        ) u_stage (
            .clk         (clk),
            .async_rst_n (async_rst_n),
            .flush       (flush),
            .up_valid    (chain_valid[i]),
            .up_data     (chain_data[i]),
            .down_ready  (chain_ready[i+1]),
            .ready       (chain_ready[i]),
            .valid       (chain_valid[i+1]),
            .data        (chain_data[i+1])
        );
    end

    assign out_valid = chain_valid[DEPTH];
    assign out_data  = chain_data[DEPTH];

    // The number of held beats changes only by what crosses the two ends of
    // the pipe; internal bubbles collapsing never change it.
    assign push = chain_valid[0];
    assign pop  = out_valid && out_ready;
    assign occ_event = occ_event_t'({push, pop});

    // A popped beat during flush is still delivered, but the count ends at
    // zero either way.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            case (occ_event)
                OCC_INC:  occupancy <= occupancy + OCC_W'(1);
                OCC_DEC:  occupancy <= occupancy - OCC_W'(1);
                default:  occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_same_domain_reg_pipe.sv
// ---------------------------------------------------------------------------
// tb_same_domain_reg_pipe
//
// Purpose:
//   Directed checks on a DEPTH=2 single-lane pipe (single beat, streaming,
//   back-pressure, flush, asynchronous reset) and a randomized run on a
//   DEPTH=3, 4-lane pipe against a beat-position reference model.
//
// Configuration macro:
//   SAME_DOMAIN_REG_PIPE_RESET_DATA_EN  enables out_data reset-value checks.
// ---------------------------------------------------------------------------
module tb_same_domain_reg_pipe;
    import same_domain_reg_pipe_pkg::*;

    localparam int W_D = 3;

    logic clk = 1'b0;
    logic async_rst_n;

    always #5 clk = ~clk;

    logic       n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [7:0] n_in_data, n_out_data;
    logic [1:0] n_occ;

    logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [31:0] w_in_data, w_out_data;
    logic [1:0]  w_occ;

    same_domain_reg_pipe #(.WIDTH(8), .CHANNELS(1), .DEPTH(2)) dut (
        .clk(clk), .async_rst_n(async_rst_n), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .occupancy(n_occ)
    );

    same_domain_reg_pipe #(.WIDTH(8), .CHANNELS(4), .DEPTH(W_D)) dut_wide (
        .clk(clk), .async_rst_n(async_rst_n), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .occupancy(w_occ)
    );

    int vectors = 0;
    int miscompares = 0;

    // Each held beat remembers which stage it sits in (0 = input side).
    typedef struct {
        logic [31:0] data;
        int          pos;
    } beat_t;

    beat_t sb[$];

    logic exp_ov, exp_ir, push, pop;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic ordy, input logic fl);
        @(negedge clk);
        n_in_valid  = v;
        n_in_data   = d;
        n_out_ready = ordy;
        n_flush     = fl;
        #1;
    endtask

    // A beat advances one stage per edge but can never land on or pass the
    // beat ahead of it; the oldest beat stops at the head until popped.
    function automatic void modelStep(input logic p_push, input logic p_pop,
                                      input logic fl, input logic [31:0] d);
        int lim;
        if (p_pop) void'(sb.pop_front());
        if (fl) begin
            sb.delete();
            return;
        end
        for (int i = 0; i < sb.size(); i++) begin
            lim = (i == 0) ? W_D - 1 : sb[i-1].pos - 1;
            sb[i].pos = (sb[i].pos + 1 < lim) ? sb[i].pos + 1 : lim;
        end
        if (p_push) sb.push_back('{data: d, pos: 0});
    endfunction

    initial begin
        async_rst_n = 1'b0;
        n_flush = 0; n_in_valid = 0; n_in_data = '0; n_out_ready = 0;
        w_flush = 0; w_in_valid = 0; w_in_data = '0; w_out_ready = 0;

        // Reset state
        #12;
        checkOutput("rst_out_valid", n_out_valid, 0);
        checkOutput("rst_occ", n_occ, 0);
        checkOutput("rst_wide_out_valid", w_out_valid, 0);
        checkOutput("rst_wide_occ", w_occ, 0);
`ifdef SAME_DOMAIN_REG_PIPE_RESET_DATA_EN
        checkOutput("rst_out_data", n_out_data, 0);
`endif
        @(negedge clk);
        async_rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", n_in_ready, 1);

        // Single beat: visible one cycle after acceptance
        applyStimulus(1, 8'hA5, 1, 0);
        checkOutput("t1_in_ready", n_in_ready, 1);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("t1_ov_early", n_out_valid, 0);
        checkOutput("t1_occ_1", n_occ, 1);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("t1_ov", n_out_valid, 1);
        checkOutput("t1_data", n_out_data, 8'hA5);
        checkOutput("t1_occ_1b", n_occ, 1);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("t1_ov_after", n_out_valid, 0);
        checkOutput("t1_occ_0", n_occ, 0);

        // Streaming 0x01..0x10 then draining
        for (int j = 0; j < 18; j++) begin
            applyStimulus(j < 16, 8'(j + 1), 1, 0);
            checkOutput("t2_in_ready", n_in_ready, 1);
            if (j >= 2) begin
                checkOutput("t2_ov", n_out_valid, 1);
                checkOutput("t2_data", n_out_data, 32'(j - 1));
            end else begin
                checkOutput("t2_ov_fill", n_out_valid, 0);
            end
        end

        // Back-pressure into a full pipe, then simultaneous push and pop
        applyStimulus(1, 8'hB0, 0, 0);
        checkOutput("t3_ir0", n_in_ready, 1);
        applyStimulus(1, 8'hB1, 0, 0);
        checkOutput("t3_ir1", n_in_ready, 1);
        checkOutput("t3_occ1", n_occ, 1);
        applyStimulus(1, 8'hB2, 0, 0);
        checkOutput("t3_ir_full", n_in_ready, 0);
        checkOutput("t3_occ_full", n_occ, 2);
        checkOutput("t3_head", n_out_data, 8'hB0);
        applyStimulus(1, 8'hB2, 1, 0);
        checkOutput("t3_ir_swap", n_in_ready, 1);
        checkOutput("t3_ov_swap", n_out_valid, 1);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("t3_occ_swap", n_occ, 2);
        checkOutput("t3_head2", n_out_data, 8'hB1);

        // Flush while full: head still delivered, no accept
        applyStimulus(1, 8'hC0, 1, 1);
        checkOutput("t4_ir_flush", n_in_ready, 0);
        checkOutput("t4_ov", n_out_valid, 1);
        checkOutput("t4_data", n_out_data, 8'hB1);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("t4_ov_after", n_out_valid, 0);
        checkOutput("t4_occ_after", n_occ, 0);
        checkOutput("t4_ir_after", n_in_ready, 1);

        // Asynchronous reset in the middle of a stream
        for (int k = 0; k < 3; k++) applyStimulus(1, 8'(8'h30 + k), 1, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("t5_ov_pre", n_out_valid, 1);
        checkOutput("t5_data_pre", n_out_data, 8'h31);
        @(posedge clk);
        #2;
        async_rst_n = 1'b0;
        #1;
        checkOutput("t5_ov_rst", n_out_valid, 0);
        checkOutput("t5_occ_rst", n_occ, 0);
`ifdef SAME_DOMAIN_REG_PIPE_RESET_DATA_EN
        checkOutput("t5_data_rst", n_out_data, 0);
`endif
        @(negedge clk);
        async_rst_n = 1'b1;
        applyStimulus(1, 8'h40, 1, 0);
        checkOutput("t5_ir", n_in_ready, 1);
        checkOutput("t5_occ0", n_occ, 0);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("t5_occ1", n_occ, 1);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("t5_ov", n_out_valid, 1);
        checkOutput("t5_data", n_out_data, 8'h40);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("t5_ov_end", n_out_valid, 0);

        // Randomized 4-lane, DEPTH=3 run against the beat-position model
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            w_in_valid  = ($urandom_range(0, 99) < 60);
            w_in_data   = $urandom;
            w_out_ready = ($urandom_range(0, 99) < 65);
            w_flush     = ($urandom_range(0, 99) < 2);
            #1;
            exp_ov = (sb.size() > 0) && (sb[0].pos == W_D - 1);
            exp_ir = !w_flush && ((sb.size() < W_D) || w_out_ready);
            checkOutput("rand_out_valid", w_out_valid, exp_ov);
            checkOutput("rand_in_ready", w_in_ready, exp_ir);
            checkOutput("rand_occupancy", w_occ, sb.size());
            checkOutput("rand_occ_bound", (w_occ <= W_D), 1);
            if (exp_ov) checkOutput("rand_out_data", w_out_data, sb[0].data);
            push = w_in_valid && exp_ir;
            pop  = exp_ov && w_out_ready;
            @(posedge clk);
            modelStep(push, pop, w_flush, w_in_data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
